// File: rtl/dc_req_pkg.sv
// Shared types and helpers for the data-cache bank requester: access sizes,
// tracker entry layout and byte-lane arithmetic.
package dc_req_pkg;

    localparam int DC_BANKS = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Per-request context needed to post-process the bank response.
    typedef struct packed {
        logic       write;
        size_e      size;
        logic       is_signed;
        logic [2:0] off;
    } trk_entry_t;

    // Byte offset inside the 8-byte word, aligned down to the access size.
    function automatic logic [2:0] align_off(input logic [2:0] lo, input size_e size);
        logic [2:0] mask;
        case (size)
            SZ_B:    mask = 3'b000;
            SZ_H:    mask = 3'b001;
            SZ_W:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return lo & ~mask;
    endfunction

    // Byte enables for an access of the given size starting at byte lane off.
    function automatic logic [7:0] byte_en(input size_e size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/dc_load_align.sv
// Load-data alignment: shifts the addressed bytes down to bit 0, keeps the
// access width and sign/zero-extends to the full data width. Stores yield 0.
module dc_load_align
    import dc_req_pkg::*;
#(
    parameter int DATA_BITS = 64
) (
    input  logic [DATA_BITS-1:0] raw_data,
    input  trk_entry_t           entry,
    output logic [DATA_BITS-1:0] load_data
);

    logic [DATA_BITS-1:0] shifted;

    // Shift to lane 0, then truncate and extend according to the access size.
    always_comb begin
        shifted   = raw_data >> {entry.off, 3'b000};
        load_data = '0;
        if (!entry.write) begin
            case (entry.size)
                SZ_B:    load_data = {{(DATA_BITS-8){entry.is_signed & shifted[7]}}, shifted[7:0]};
                SZ_H:    load_data = {{(DATA_BITS-16){entry.is_signed & shifted[15]}}, shifted[15:0]};
                SZ_W:    load_data = {{(DATA_BITS-32){entry.is_signed & shifted[31]}}, shifted[31:0]};
                default: load_data = shifted;
            endcase
        end
    end

endmodule

// File: rtl/dc_bank_requester.sv
// Core-side initiator for the banked data cache. Registers one request at a
// time towards the banks, tracks outstanding requests in order and returns
// aligned, extended load data to the core.
module dc_bank_requester
    import dc_req_pkg::*;
#(
    parameter int ADDR_BITS = 39,
    parameter int DATA_BITS = 64,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 core_req_valid,
    output logic                 core_req_retry,
    input  logic                 core_req_write,
    input  logic [1:0]           core_req_size,
    input  logic                 core_req_signed,
    input  logic [ADDR_BITS-1:0] core_req_addr,
    input  logic [DATA_BITS-1:0] core_req_data,
    output logic                 core_ack_valid,
    input  logic                 core_ack_retry,
    output logic [DATA_BITS-1:0] core_ack_data,
    output logic                 dc_req_valid,
    input  logic                 dc_req_retry,
    output logic                 dc_req_write,
    output logic [1:0]           dc_req_bank,
    output logic [ADDR_BITS-1:0] dc_req_addr,
    output logic [DATA_BITS-1:0] dc_req_data,
    output logic [7:0]           dc_req_be,
    input  logic                 dc_ack_valid,
    output logic                 dc_ack_retry,
    input  logic [DATA_BITS-1:0] dc_ack_data,
    output logic                 err_ack
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BANK_W = $clog2(DC_BANKS);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } req_state_e;

    req_state_e           state;
    req_state_e           state_nxt;
    logic                 req_accept;
    logic                 full;
    logic [CNT_W-1:0]     count;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    trk_entry_t           trk_mem [DEPTH];
    trk_entry_t           req_entry;
    size_e                req_size;
    logic [2:0]           req_off;
    logic                 dc_ack_accept;
    logic                 trk_pop;
    logic [DATA_BITS-1:0] load_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign req_size  = size_e'(core_req_size);
    assign req_off   = align_off(core_req_addr[2:0], req_size);
    assign req_entry = '{write: core_req_write, size: req_size,
                         is_signed: core_req_signed, off: req_off};

    assign dc_req_valid  = (state == S_SEND);
    assign dc_ack_retry  = core_ack_valid & core_ack_retry;
    assign dc_ack_accept = dc_ack_valid & ~dc_ack_retry;
    assign trk_pop       = dc_ack_accept & (count != '0);

    // Request FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Request FSM next state and core-side back-pressure; full blocks even if a pop is pending.
    always_comb begin
        state_nxt      = state;
        core_req_retry = full;
        req_accept     = 1'b0;
        case (state)
            S_IDLE: begin
                req_accept = core_req_valid & ~full;
                if (req_accept) state_nxt = S_SEND;
            end
            S_SEND: begin
                core_req_retry = dc_req_retry | full;
                req_accept     = core_req_valid & ~(dc_req_retry | full);
                if (!dc_req_retry && !req_accept) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bank request register, loaded on every accepted core request and held otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dc_req_write <= 1'b0;
            dc_req_bank  <= '0;
            dc_req_addr  <= '0;
            dc_req_data  <= '0;
            dc_req_be    <= '0;
        end else if (req_accept) begin
            dc_req_write <= core_req_write;
            dc_req_bank  <= core_req_addr[3 +: BANK_W];
            dc_req_addr  <= {core_req_addr[ADDR_BITS-1:3], 3'b000};
            dc_req_data  <= core_req_data << {req_off, 3'b000};
            dc_req_be    <= byte_en(req_size, req_off);
        end
    end

    // Tracker pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (req_accept) wr_ptr <= ptr_inc(wr_ptr);
            if (trk_pop)    rd_ptr <= ptr_inc(rd_ptr);
            case ({req_accept, trk_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tracker storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (req_accept) trk_mem[wr_ptr] <= req_entry;
    end

    dc_load_align #(
        .DATA_BITS (DATA_BITS)
    ) u_load_align (
        .raw_data  (dc_ack_data),
        .entry     (trk_mem[rd_ptr]),
        .load_data (load_data)
    );

    // Core response register and sticky unexpected-ack flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            core_ack_valid <= 1'b0;
            core_ack_data  <= '0;
            err_ack        <= 1'b0;
        end else begin
            if (trk_pop) begin
                core_ack_valid <= 1'b1;
                core_ack_data  <= load_data;
            end else if (core_ack_valid && !core_ack_retry) begin
                core_ack_valid <= 1'b0;
            end
            if (dc_ack_accept && (count == '0)) err_ack <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dc_bank_requester.sv
// Scoreboard bench for dc_bank_requester: randomized and directed stimulus,
// with a monitor that checks every interface against a byte-arithmetic model.
module tb_dc_bank_requester;

    localparam int ADDR_BITS = 39;
    localparam int DATA_BITS = 64;
    localparam int DEPTH     = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 core_req_valid;
    logic                 core_req_retry;
    logic                 core_req_write;
    logic [1:0]           core_req_size;
    logic                 core_req_signed;
    logic [ADDR_BITS-1:0] core_req_addr;
    logic [DATA_BITS-1:0] core_req_data;
    logic                 core_ack_valid;
    logic                 core_ack_retry;
    logic [DATA_BITS-1:0] core_ack_data;
    logic                 dc_req_valid;
    logic                 dc_req_retry;
    logic                 dc_req_write;
    logic [1:0]           dc_req_bank;
    logic [ADDR_BITS-1:0] dc_req_addr;
    logic [DATA_BITS-1:0] dc_req_data;
    logic [7:0]           dc_req_be;
    logic                 dc_ack_valid;
    logic                 dc_ack_retry;
    logic [DATA_BITS-1:0] dc_ack_data;
    logic                 err_ack;

    always #5 clk = ~clk;

    dc_bank_requester #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .core_req_valid  (core_req_valid),
        .core_req_retry  (core_req_retry),
        .core_req_write  (core_req_write),
        .core_req_size   (core_req_size),
        .core_req_signed (core_req_signed),
        .core_req_addr   (core_req_addr),
        .core_req_data   (core_req_data),
        .core_ack_valid  (core_ack_valid),
        .core_ack_retry  (core_ack_retry),
        .core_ack_data   (core_ack_data),
        .dc_req_valid    (dc_req_valid),
        .dc_req_retry    (dc_req_retry),
        .dc_req_write    (dc_req_write),
        .dc_req_bank     (dc_req_bank),
        .dc_req_addr     (dc_req_addr),
        .dc_req_data     (dc_req_data),
        .dc_req_be       (dc_req_be),
        .dc_ack_valid    (dc_ack_valid),
        .dc_ack_retry    (dc_ack_retry),
        .dc_ack_data     (dc_ack_data),
        .err_ack         (err_ack)
    );

    typedef struct {
        logic                 write;
        logic [1:0]           size;
        logic                 sgn;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } req_t;

    typedef struct {
        logic                 write;
        logic [1:0]           bank;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
        logic [7:0]           be;
    } dcreq_t;

    // Stimulus-owned
    req_t        dir_q[$];
    logic [63:0] ackdata_q[$];
    bit          gen_req = 1'b0;
    int          p_req = 0, p_dcretry = 0, p_ack = 0, p_ackretry = 0;
    bit          final_chk = 1'b0;

    // Monitor-owned
    dcreq_t      dcq[$];
    req_t        trk_q[$];
    logic [63:0] resp_q[$];
    bit          req_taken = 1'b0, ack_taken = 1'b0, was_rst = 1'b0, model_err = 1'b0;
    int          issued_pending = 0;
    int          checks = 0, errors = 0;

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic int lane_off(input logic [ADDR_BITS-1:0] addr, input logic [1:0] s);
        int nb;
        nb = nbytes(s);
        return (int'(addr % 8) / nb) * nb;
    endfunction

    function automatic dcreq_t model_dcreq(input req_t r);
        dcreq_t d;
        int     off;
        int     nb;
        off     = lane_off(r.addr, r.size);
        nb      = nbytes(r.size);
        d.write = r.write;
        d.bank  = 2'((r.addr / 8) % 4);
        d.addr  = r.addr - (r.addr % 8);
        d.be    = 8'(((1 << nb) - 1) << off);
        d.data  = r.data * (64'd1 << (8 * off));
        return d;
    endfunction

    function automatic logic [63:0] model_load(input req_t r, input logic [63:0] raw);
        logic [63:0] v;
        logic [63:0] lim;
        int          off;
        int          nb;
        if (r.write) return 64'd0;
        off = lane_off(r.addr, r.size);
        nb  = nbytes(r.size);
        v   = raw / (64'd1 << (8 * off));
        if (nb < 8) begin
            lim = 64'd1 << (8 * nb);
            v   = v % lim;
            if (r.sgn && (v >= (lim >> 1))) v = v - lim;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (was_rst) begin
                chk("reset_ctrl_outputs", 64'({core_req_retry, core_ack_valid, dc_req_valid, dc_ack_retry,
                                               err_ack, dc_req_write, dc_req_bank, dc_req_be}), 64'd0);
                chk("reset_dc_req_addr", 64'(dc_req_addr), 64'd0);
                chk("reset_dc_req_data", dc_req_data, 64'd0);
                chk("reset_core_ack_data", core_ack_data, 64'd0);
            end
            if (!reset) begin
                dcq.delete();
                trk_q.delete();
                resp_q.delete();
                model_err      = 1'b0;
                req_taken      = 1'b0;
                ack_taken      = 1'b0;
                issued_pending = 0;
                was_rst        = 1'b1;
            end else begin
                was_rst = 1'b0;
                // checks against model state accumulated up to the previous edge
                chk("err_ack", 64'(err_ack), 64'(model_err));
                chk("core_ack_valid", 64'(core_ack_valid), 64'(resp_q.size() > 0));
                if (core_ack_valid && resp_q.size() > 0)
                    chk("core_ack_data", core_ack_data, resp_q[0]);
                chk("dc_ack_retry", 64'(dc_ack_retry), 64'((resp_q.size() > 0) && core_ack_retry));
                chk("dc_req_valid", 64'(dc_req_valid), 64'(dcq.size() > 0));
                if (dc_req_valid && dcq.size() > 0) begin
                    chk("dc_req_write", 64'(dc_req_write), 64'(dcq[0].write));
                    chk("dc_req_bank", 64'(dc_req_bank), 64'(dcq[0].bank));
                    chk("dc_req_addr", 64'(dc_req_addr), 64'(dcq[0].addr));
                    chk("dc_req_data", dc_req_data, dcq[0].data);
                    chk("dc_req_be", 64'(dc_req_be), 64'(dcq[0].be));
                end
                chk("core_req_retry", 64'(core_req_retry),
                    64'((trk_q.size() == DEPTH) || ((dcq.size() > 0) && dc_req_retry)));
                if (final_chk)
                    chk("final_queues_empty", 64'(dcq.size() + trk_q.size() + resp_q.size()), 64'd0);

                // model updates for transfers happening at the coming edge
                if (core_ack_valid && !core_ack_retry && resp_q.size() > 0)
                    void'(resp_q.pop_front());
                if (dc_req_valid && !dc_req_retry) begin
                    if (dcq.size() > 0) void'(dcq.pop_front());
                    issued_pending++;
                end
                ack_taken = dc_ack_valid && !dc_ack_retry;
                if (ack_taken) begin
                    if (trk_q.size() > 0) begin
                        resp_q.push_back(model_load(trk_q.pop_front(), dc_ack_data));
                        if (issued_pending > 0) issued_pending--;
                    end else begin
                        model_err = 1'b1;
                    end
                end
                req_taken = core_req_valid && !core_req_retry;
                if (req_taken) begin
                    req_t r;
                    r.write = core_req_write;
                    r.size  = core_req_size;
                    r.sgn   = core_req_signed;
                    r.addr  = core_req_addr;
                    r.data  = core_req_data;
                    trk_q.push_back(r);
                    dcq.push_back(model_dcreq(r));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        req_t r;
        @(negedge clk);
        if (core_req_valid && req_taken) core_req_valid = 1'b0;
        if (!core_req_valid) begin
            if (dir_q.size() > 0) begin
                r = dir_q.pop_front();
                core_req_valid = 1'b1;
            end else if (gen_req && ($urandom_range(99) < p_req)) begin
                r.write = 1'($urandom_range(1));
                r.size  = 2'($urandom_range(3));
                r.sgn   = 1'($urandom_range(1));
                r.addr  = ADDR_BITS'({$urandom(), $urandom()});
                r.data  = {$urandom(), $urandom()};
                core_req_valid = 1'b1;
            end
            if (core_req_valid) begin
                core_req_write  = r.write;
                core_req_size   = r.size;
                core_req_signed = r.sgn;
                core_req_addr   = r.addr;
                core_req_data   = r.data;
            end
        end
        dc_req_retry   = ($urandom_range(99) < p_dcretry);
        core_ack_retry = ($urandom_range(99) < p_ackretry);
        if (dc_ack_valid && ack_taken) dc_ack_valid = 1'b0;
        if (!dc_ack_valid && issued_pending > 0 && ($urandom_range(99) < p_ack)) begin
            dc_ack_valid = 1'b1;
            if (ackdata_q.size() > 0) dc_ack_data = ackdata_q.pop_front();
            else                      dc_ack_data = {$urandom(), $urandom()};
        end
    endtask

    task automatic set_knobs(input bit g, input int pr, input int pdr, input int pa, input int par);
        gen_req = g; p_req = pr; p_dcretry = pdr; p_ack = pa; p_ackretry = par;
    endtask

    initial begin
        reset = 1'b0;
        core_req_valid = 1'b0; core_req_write = 1'b0; core_req_size = 2'd0; core_req_signed = 1'b0;
        core_req_addr = '0; core_req_data = '0; core_ack_retry = 1'b0;
        dc_req_retry = 1'b0; dc_ack_valid = 1'b0; dc_ack_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // directed loads and store with known bank data
        set_knobs(1'b0, 0, 0, 100, 0);
        dir_q.push_back('{write: 1'b0, size: 2'd3, sgn: 1'b0, addr: 39'h48,  data: 64'd0});
        ackdata_q.push_back(64'h1122_3344_5566_7788);
        dir_q.push_back('{write: 1'b0, size: 2'd0, sgn: 1'b1, addr: 39'h105, data: 64'd0});
        ackdata_q.push_back(64'h0000_8000_0000_0000);
        dir_q.push_back('{write: 1'b0, size: 2'd0, sgn: 1'b0, addr: 39'h105, data: 64'd0});
        ackdata_q.push_back(64'h0000_8000_0000_0000);
        dir_q.push_back('{write: 1'b1, size: 2'd1, sgn: 1'b0, addr: 39'h0E,  data: 64'hBEEF});
        ackdata_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
        repeat (24) step();

        // fill the tracker with no bank acks, then release acks
        set_knobs(1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            dir_q.push_back('{write: 1'b0, size: 2'(i % 4), sgn: 1'b1, addr: 39'(i * 8 + 3), data: 64'd0});
        repeat (12) step();
        p_ack = 100;
        repeat (24) step();

        // bank back-pressure for 3 cycles, then core back-pressure on the response
        set_knobs(1'b0, 0, 0, 0, 0);
        dir_q.push_back('{write: 1'b0, size: 2'd2, sgn: 1'b1, addr: 39'h7C, data: 64'd0});
        step();
        p_dcretry = 100;
        repeat (3) step();
        p_dcretry  = 0;
        p_ackretry = 100;
        p_ack      = 100;
        repeat (4) step();
        p_ackretry = 0;
        repeat (8) step();

        // randomized traffic, then drain
        set_knobs(1'b1, 60, 30, 50, 30);
        repeat (1500) step();
        set_knobs(1'b0, 0, 0, 100, 0);
        repeat (40) step();

        // unsolicited bank ack on an empty tracker; err_ack must stick
        @(negedge clk);
        dc_ack_valid = 1'b1;
        dc_ack_data  = 64'h0123_4567_89AB_CDEF;
        repeat (6) step();

        // reset in the middle of a burst
        set_knobs(1'b1, 80, 20, 40, 20);
        repeat (25) step();
        @(negedge clk);
        reset          = 1'b0;
        core_req_valid = 1'b0;
        dc_ack_valid   = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        set_knobs(1'b1, 60, 30, 50, 30);
        repeat (300) step();
        set_knobs(1'b0, 0, 0, 100, 0);
        repeat (60) step();

        @(negedge clk);
        final_chk = 1'b1;
        @(negedge clk);
        final_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
